// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl: runs one dsc_mul job at a time.
// Takes an operand set on a valid/ready input, holds the operands on mul_a..d,
// pulses the multiplier through a one-cycle clear, enables it until ov, and
// returns the product plus the number of RUN cycles on a valid/ready output.
// Every output is a register or a decode of the state register, so there is
// no combinational path from any input to any output.
module dsc_mul_ctrl #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 48,
    parameter int ZERO_SKIP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    input  logic [WIDTH-1:0]       in_d,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*WIDTH-1:0]     out_z,
    output logic [CNT_WIDTH-1:0]   out_cycles,
    output logic                   busy,
    output logic                   mul_rst,
    output logic                   mul_en,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic [WIDTH-1:0]       mul_c,
    output logic [WIDTH-1:0]       mul_d,
    input  logic [4*WIDTH-1:0]     mul_z,
    input  logic                   mul_ov
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [4*WIDTH-1:0]     z_q, z_d;
    logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   any_zero;

    // Saturating increment: the counter sticks at all-ones on very long jobs.
    assign cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
    assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);

    // State, operand, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            z_q     <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            z_q     <= z_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic; abort beats a coincident ov, stray ov outside RUN is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        z_d     = z_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    c_d   = in_c;
                    d_d   = in_d;
                    cnt_d = '0;
                    if ((ZERO_SKIP != 0) && any_zero) begin
                        z_d     = '0;
                        cyc_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mul_ov) begin
                    z_d     = mul_z;
                    cyc_d   = cnt_inc;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign mul_en     = (state_q == S_RUN);
    assign mul_rst    = (state_q != S_RUN);
    assign out_valid  = (state_q == S_DONE);
    assign out_z      = z_q;
    assign out_cycles = cyc_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_c      = c_q;
    assign mul_d      = d_q;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Scoreboard bench for dsc_mul_ctrl with a behavioural dsc_mul stub.
// The driver pushes the expected result of each accepted job; a negedge
// monitor pops and compares on every output handshake.
module tb_dsc_mul_ctrl;

    localparam int W   = 10;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, abort, out_valid, out_ready;
    logic [W-1:0]    in_a, in_b, in_c, in_d;
    logic [4*W-1:0]  out_z, mul_z;
    logic [CW-1:0]   out_cycles;
    logic            busy, mul_rst, mul_en, mul_ov;
    logic [W-1:0]    mul_a, mul_b, mul_c, mul_d;

    typedef struct {
        logic [63:0] z;
        logic [63:0] cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           en_seen  = 0;
    int           busy_seen = 0;
    int           stub_n   = 1;
    int           scnt     = 0;
    logic         stray_ov = 1'b0;
    logic [W-1:0] cur_a = '0, cur_b = '0, cur_c = '0, cur_d = '0;

    always #5 clk = ~clk;

    dsc_mul_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .ZERO_SKIP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_cycles(out_cycles),
        .busy(busy), .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    // dsc_mul stub: ov during the stub_n-th enabled cycle, z = a*b*c*d
    always @(posedge clk) begin
        if (mul_rst) scnt <= 0;
        else if (mul_en) scnt <= scnt + 1;
    end
    assign mul_ov = (mul_en && (scnt == stub_n - 1)) || stray_ov;
    assign mul_z  = {30'd0, mul_a} * {30'd0, mul_b} * {30'd0, mul_c} * {30'd0, mul_d};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else pass_cnt++;
    endtask

    // Monitor: activity counters, operand stability, result scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_en) en_seen++;
            if (busy) busy_seen++;
            if (busy || out_valid)
                chk("operands_stable", {mul_a, mul_b, mul_c, mul_d}, {cur_a, cur_b, cur_c, cur_d});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_z", 64'(out_z), e.z);
                    chk("out_cycles", 64'(out_cycles), e.cyc);
                end
            end
        end
    end

    // mode: 0 normal, 1 abort in RUN cycle k, 2 reset in RUN cycle k
    task automatic do_job(input logic [W-1:0] a, b, c, d, input int n, input int mode,
                          input int k, input int hold, input bit stray);
        int   t, e, e0, b0;
        bit   skip;
        exp_t x;
        logic [39:0] z0;
        logic [CW-1:0] c0;
        skip   = (a == 0) || (b == 0) || (c == 0) || (d == 0);
        stub_n = n;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1'b1;
        if (stray) stray_ov = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cur_a = a; cur_b = b; cur_c = c; cur_d = d;
        if (mode == 0) begin
            x.z   = skip ? 64'd0 : 64'(a) * 64'(b) * 64'(c) * 64'(d);
            x.cyc = skip ? 64'd0 : 64'((n > SAT) ? SAT : n);
            exp_q.push_back(x);
        end
        e = 1; e0 = en_seen; b0 = busy_seen;
        if (stray && !skip) begin @(posedge clk); #1; e++; end
        stray_ov = 1'b0;
        if (mode != 0) begin
            while (e < k + 1) begin @(posedge clk); #1; e++; end
            if (mode == 1) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_out_valid", 64'(out_valid), 64'd0);
                chk("abort_in_ready", 64'(in_ready), 64'd1);
                chk("abort_mul_rst", 64'(mul_rst), 64'd1);
                chk("abort_busy", 64'(busy), 64'd0);
                @(posedge clk); #1;
                chk("abort_no_result", 64'(out_valid), 64'd0);
            end else begin
                rst_n = 1'b0;
                #1;
                chk("arst_state", {59'd0, in_ready, mul_rst, mul_en, busy, out_valid}, 64'b11000);
                chk("arst_out", 64'(out_z) | 64'(out_cycles), 64'd0);
                chk("arst_ops", {mul_a, mul_b, mul_c, mul_d}, 64'd0);
                cur_a = '0; cur_b = '0; cur_c = '0; cur_d = '0;
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
            end
            return;
        end
        while (!out_valid && e < 200) begin @(posedge clk); #1; e++; end
        chk("latency", 64'(e), skip ? 64'd1 : 64'(n + 2));
        chk("en_cycles", 64'(en_seen - e0), skip ? 64'd0 : 64'(n));
        chk("busy_cycles", 64'(busy_seen - b0), skip ? 64'd0 : 64'(n + 1));
        z0 = out_z; c0 = out_cycles;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = 10'($urandom); in_b = 10'($urandom); in_c = 10'($urandom); in_d = 10'($urandom);
            @(posedge clk); #1;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_stable", {out_z, 19'd0, out_cycles}, {z0, 19'd0, c0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        #12;
        chk("rst_state", {59'd0, in_ready, mul_rst, mul_en, busy, out_valid}, 64'b11000);
        chk("rst_out", 64'(out_z) | 64'(out_cycles), 64'd0);
        chk("rst_ops", {mul_a, mul_b, mul_c, mul_d}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_job(3, 5, 7, 2, 20, 0, 0, 0, 0);     // basic, z=210 cycles=20
        do_job(0, 9, 9, 9, 5, 0, 0, 0, 0);      // zero skip
        do_job(4, 4, 4, 4, 6, 0, 0, 10, 0);     // result backpressure
        do_job(3, 5, 7, 2, 20, 1, 5, 0, 0);     // abort in RUN cycle 5
        do_job(1, 1, 1, 1, 4, 0, 0, 0, 0);
        do_job(2, 3, 4, 5, 7, 1, 7, 0, 0);      // abort coincides with ov
        do_job(2, 3, 4, 5, 7, 0, 0, 0, 1);      // stray ov in IDLE and CLEAR
        do_job(1023, 1023, 1023, 1023, 1, 0, 0, 0, 0); // max product, N=1
        do_job(1, 2, 3, 4, 40, 0, 0, 0, 0);     // counter saturates
        do_job(5, 5, 5, 5, 30, 2, 10, 0, 0);    // reset mid-RUN
        do_job(6, 7, 8, 9, 3, 0, 0, 0, 0);

        for (int j = 0; j < 30; j++) begin
            logic [W-1:0] ra, rb, rc, rd;
            int n, mode, k;
            ra = ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            rb = ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            rc = ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            rd = ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            n = $urandom_range(1, 40);
            mode = 0; k = 0;
            if (ra != 0 && rb != 0 && rc != 0 && rd != 0 && $urandom_range(0, 5) == 0) begin
                mode = 1; k = $urandom_range(1, n);
            end
            do_job(ra, rb, rc, rd, n, mode, k, $urandom_range(0, 4), 1'($urandom_range(0, 4) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
